alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 171 +++++++++++++++++
 tb/tb_alu_seq.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU: single-cycle logic/arith ops, WIDTH-step iterative mul/div
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       FS,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] F,
  output logic             Valid,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic             valid_q, valid_d;
  logic [SHW-1:0]   cnt_q, cnt_d;

  logic             accept;
  logic             is_iter;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sum, dif, sc_f;
  logic             sc_v;

  assign shamt   = B[SHW-1:0];
  assign sum     = A + B;
  assign dif     = A - B;
  assign is_iter = (FS[4:2] == 3'b100);

  always_comb begin
    sc_f = '0;
    sc_v = 1'b1;
    case (FS)
      5'd0:  sc_f = A << shamt;
      5'd1:  sc_f = A >> shamt;
      5'd2:  sc_f = $unsigned($signed(A) >>> shamt);
      5'd3: begin
        sc_f = sum;
        sc_v = ~((A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]));
      end
      // the adder sees ~B for SUB, so operand signs "agree" when A and B differ
      5'd4: begin
        sc_f = dif;
        sc_v = ~((A[WIDTH-1] != B[WIDTH-1]) && (dif[WIDTH-1] != A[WIDTH-1]));
      end
      5'd5:  sc_f = A & B;
      5'd6:  sc_f = A | B;
      5'd7:  sc_f = A ^ B;
      5'd8:  sc_f = A;
      5'd9:  sc_f = B;
      5'd10: sc_f = ~A;
      5'd11: sc_f = ~B;
      5'd12: sc_f = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      5'd13: sc_f = {{(WIDTH-1){1'b0}}, (A < B)};
      5'd14: sc_f = {{(WIDTH-1){1'b0}}, (A == B)};
      5'd15: sc_f = '0;
      default: begin
        sc_f = '0;
        sc_v = 1'b0;
      end
    endcase
  end

  // {acc_q, mq_q} is the double-width working register shared by mul and div
  logic [WIDTH:0]   mul_sum, rem_sh;
  logic [WIDTH-1:0] mul_acc, mul_mq, div_diff, div_acc, div_mq;
  logic [WIDTH-1:0] step_acc, step_mq, iter_f;
  logic             div_ok;

  assign mul_sum  = {1'b0, acc_q} + {1'b0, (mq_q[0] ? b_q : {WIDTH{1'b0}})};
  assign mul_acc  = mul_sum[WIDTH:1];
  assign mul_mq   = {mul_sum[0], mq_q[WIDTH-1:1]};
  assign rem_sh   = {acc_q, mq_q[WIDTH-1]};
  assign div_ok   = (rem_sh >= {1'b0, b_q});
  assign div_diff = rem_sh[WIDTH-1:0] - b_q;
  assign div_acc  = div_ok ? div_diff : rem_sh[WIDTH-1:0];
  assign div_mq   = {mq_q[WIDTH-2:0], div_ok};
  assign step_acc = op_q[1] ? div_acc : mul_acc;
  assign step_mq  = op_q[1] ? div_mq : mul_mq;

  always_comb begin
    case (op_q)
      2'd0:    iter_f = mul_mq;
      2'd1:    iter_f = mul_acc;
      2'd2:    iter_f = div_mq;
      default: iter_f = div_acc;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    b_d      = b_q;
    acc_d    = acc_q;
    mq_d     = mq_q;
    cnt_d    = cnt_q;
    f_d      = f_q;
    valid_d  = valid_q;
    in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    accept   = in_valid && in_ready;
    case (state_q)
      CALC: begin
        acc_d = step_acc;
        mq_d  = step_mq;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SHW'(WIDTH - 1)) begin
          state_d = DONE;
          f_d     = iter_f;
          valid_d = 1'b1;
          cnt_d   = '0;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: ;
    endcase
    if (accept) begin
      if (is_iter) begin
        state_d = CALC;
        op_d    = FS[1:0];
        b_d     = B;
        acc_d   = '0;
        mq_d    = A;
        cnt_d   = '0;
      end else begin
        state_d = DONE;
        f_d     = sc_f;
        valid_d = sc_v;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      cnt_q   <= '0;
      f_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      cnt_q   <= cnt_d;
      f_q     <= f_d;
      valid_q <= valid_d;
    end
  end

  assign F         = f_q;
  assign Valid     = valid_q;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == CALC);

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq with directed vectors and random ops
module tb_alu_seq;
  localparam int W = 32;
  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready, Valid, busy;
  logic [W-1:0] A, B, F;
  logic [4:0]   FS;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .FS(FS), .out_valid(out_valid), .out_ready(out_ready),
    .F(F), .Valid(Valid), .busy(busy)
  );

  typedef struct {
    logic [W-1:0] f;
    logic         v;
    int           lat;
    int           acc_cyc;
    logic [4:0]   fs;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   seen_cur = 0;
  bit   rdy_rand = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rdy_rand) out_ready = (($urandom % 4) != 0);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W:0] ref_op(input logic [4:0] fs, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    longint          sa, sbv, s;
    longint unsigned p;
    logic [W-1:0]    f;
    logic            v;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    p   = 64'(a) * 64'(b);
    f   = '0;
    v   = 1'b1;
    case (fs)
      5'd0:  f = a << b[4:0];
      5'd1:  f = a >> b[4:0];
      5'd2:  f = W'(sa >>> b[4:0]);
      5'd3:  begin s = sa + sbv; f = s[W-1:0]; v = (s <= MAXS) && (s >= MINS); end
      5'd4:  begin s = sa - sbv; f = s[W-1:0]; v = (s <= MAXS) && (s >= MINS); end
      5'd5:  f = a & b;
      5'd6:  f = a | b;
      5'd7:  f = a ^ b;
      5'd8:  f = a;
      5'd9:  f = b;
      5'd10: f = ~a;
      5'd11: f = ~b;
      5'd12: f = (sa < sbv) ? 1 : 0;
      5'd13: f = (a < b) ? 1 : 0;
      5'd14: f = (a == b) ? 1 : 0;
      5'd15: f = '0;
      5'd16: f = p[31:0];
      5'd17: f = p[63:32];
      5'd18: f = (b == 0) ? '1 : a / b;
      5'd19: f = (b == 0) ? a : a % b;
      default: begin f = '0; v = 1'b0; end
    endcase
    return {v, f};
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // called at posedge+1; returns at posedge+1 just after the accepting edge
  task automatic issue(input logic [4:0] fs, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] f_exp, input logic v_exp);
    int   t;
    exp_t e;
    FS = fs; A = a; B = b; in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("accept_wait", in_ready, 1);
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e.f = f_exp; e.v = v_exp; e.fs = fs;
    e.lat = (fs >= 16 && fs <= 19) ? W + 1 : 1;
    e.acc_cyc = cyc - 1;
    sb.push_back(e);
    in_valid = 1'b0;
  endtask

  task automatic issue_ref(input logic [4:0] fs, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] r;
    r = ref_op(fs, a, b);
    issue(fs, a, b, r[W-1:0], r[W]);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", out_valid, 0);
      end else begin
        if (!seen_cur) begin
          chk("latency", 64'(cyc - sb[0].acc_cyc), 64'(sb[0].lat));
          seen_cur = 1;
        end
        if (out_ready) begin
          exp_t e;
          e = sb.pop_front();
          chk($sformatf("F fs=%0d", e.fs), F, e.f);
          chk($sformatf("Valid fs=%0d", e.fs), Valid, e.v);
          seen_cur = 0;
        end
      end
    end
  end

  function automatic logic [W-1:0] pick();
    case ($urandom % 6)
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return W'($urandom % 40);
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int t, hits;
    logic [W-1:0] xa, xb;
    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; FS = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset F", F, 0);
    chk("reset Valid", Valid, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset in_ready", in_ready, 1);
    sync();
    out_ready = 1'b1;

    issue(5'd3, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0);
    issue(5'd2, 32'h8000_0000, 32'h24, 32'hF800_0000, 1'b1);
    issue(5'd4, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b0);
    issue(5'd25, 32'h1234, 32'h5678, 32'h0, 1'b0);
    issue(5'd18, 32'd100, 32'd0, 32'hFFFF_FFFF, 1'b1);
    issue(5'd19, 32'd100, 32'd0, 32'd100, 1'b1);
    issue(5'd19, 32'd100, 32'd7, 32'd2, 1'b1);

    // MULHU with a competing request held during CALC
    issue(5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
    FS = 5'd3; A = 32'd1; B = 32'd1; in_valid = 1'b1;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      chk($sformatf("calc busy c%0d", i), busy, 1);
      chk($sformatf("calc in_ready c%0d", i), in_ready, 0);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("mulhu busy_done", busy, 0);
    chk("mulhu out_valid", out_valid, 1);
    sync();

    // result held under backpressure, then retire+accept in one cycle
    rdy_rand = 0; out_ready = 1'b0;
    xa = 32'hDEAD_BEEF; xb = 32'h0F0F_1234;
    issue(5'd7, xa, xb, xa ^ xb, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold F", F, xa ^ xb);
      chk("hold in_ready", in_ready, 0);
      chk("hold out_valid", out_valid, 1);
    end
    sync();
    out_ready = 1'b1;
    issue(5'd4, 32'd10, 32'd3, 32'd7, 1'b1);

    // abort a DIVU mid-flight
    issue(5'd18, 32'd1000, 32'd3, 32'd333, 1'b1);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    seen_cur = 0;
    @(negedge clk);
    chk("abort out_valid", out_valid, 0);
    chk("abort F", F, 0);
    chk("abort Valid", Valid, 0);
    chk("abort busy", busy, 0);
    chk("abort in_ready", in_ready, 1);
    hits = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) hits++;
    end
    chk("abort no result", hits, 0);
    sync();

    rdy_rand = 1;
    for (int n = 0; n < 300; n++) begin
      issue_ref(5'($urandom_range(0, 31)), pick(), pick());
      if (($urandom % 4) == 0) repeat ($urandom % 3) sync();
    end

    rdy_rand = 0;
    out_ready = 1'b1;
    t = 0;
    while (sb.size() > 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("drain", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
